// File: rtl/osd_di_type_demux.sv
// osd_di_type_demux
//   Routes DI packets to one of N_OUT output links by matching the FLAGS flit
//   (TYPE[15:14], TYPE_SUB[13:10]) against a priority-ordered mask/value table.
//   Header flits up to and including FLAGS are buffered, replayed to the chosen
//   output, then the remaining body is streamed through combinationally.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in / in_ready   input DI link (data, last, valid) and its accept
//   out / out_ready N_OUT output DI links and their per-link ready
//   route_valid     one-cycle pulse in the first replay cycle of each packet
//   route_sel       output chosen for that packet, valid with route_valid

package osd_di_pkg;
  typedef struct packed {
    logic [15:0] data;
    logic        last;
    logic        valid;
  } dii_flit;
endpackage

module osd_di_type_demux
  import osd_di_pkg::*;
#(
  parameter int                    N_OUT       = 2,
  parameter int                    FLAGS_IDX   = 2,
  parameter logic [N_OUT-1:0][5:0] MATCH_VAL   = {6'b000000, 6'b000000},
  parameter logic [N_OUT-1:0][5:0] MATCH_MASK  = {6'b000000, 6'b110000},
  parameter int                    DEFAULT_OUT = N_OUT-1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  dii_flit                   in,
  output logic                      in_ready,
  output dii_flit [N_OUT-1:0]       out,
  input  logic [N_OUT-1:0]          out_ready,
  output logic                      route_valid,
  output logic [$clog2(N_OUT)-1:0]  route_sel
);

  localparam int SW   = $clog2(N_OUT);
  localparam int NBUF = FLAGS_IDX + 1;
  localparam int CW   = $clog2(FLAGS_IDX + 2);  // holds 0..NBUF

  typedef enum logic [1:0] {COLLECT, DRAIN, STREAM} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, rd, nbuf;
  logic [SW-1:0]   sel, match_sel;
  logic            pkt_done;
  logic [15:0]     hdr_data [NBUF];
  logic            hdr_last [NBUF];
  logic            rd_last;
  logic            flags_flit;
  dii_flit         cur;

  assign rd_last    = (rd == nbuf - 1'b1);
  assign flags_flit = (cnt == CW'(FLAGS_IDX));

  // Priority match: scan downwards so the lowest matching index wins.
  always_comb begin
    match_sel = SW'(DEFAULT_OUT);
    for (int i = N_OUT-1; i >= 0; i--)
      if (((in.data[15:10] ^ MATCH_VAL[i]) & MATCH_MASK[i]) == 6'd0)
        match_sel = SW'(i);
  end

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= COLLECT;
      cnt         <= '0;
      rd          <= '0;
      nbuf        <= '0;
      sel         <= SW'(DEFAULT_OUT);
      pkt_done    <= 1'b0;
      route_valid <= 1'b0;
      route_sel   <= '0;
    end else begin
      state       <= state_nx;
      route_valid <= 1'b0;
      case (state)
        COLLECT: if (in.valid) begin
          if (flags_flit) begin
            sel         <= match_sel;
            nbuf        <= CW'(NBUF);
            pkt_done    <= in.last;
            route_valid <= 1'b1;
            route_sel   <= match_sel;
            cnt         <= '0;
          end else if (in.last) begin
            // short packet: never saw FLAGS, take the default route
            sel         <= SW'(DEFAULT_OUT);
            nbuf        <= cnt + 1'b1;
            pkt_done    <= 1'b1;
            route_valid <= 1'b1;
            route_sel   <= SW'(DEFAULT_OUT);
            cnt         <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DRAIN: if (out_ready[sel]) begin
          if (rd_last) rd <= '0;
          else         rd <= rd + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Header buffer needs no reset; contents only matter after being written.
  always_ff @(posedge clk) begin
    if (state == COLLECT && in.valid) begin
      hdr_data[cnt] <= in.data;
      hdr_last[cnt] <= in.last;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      COLLECT: if (in.valid && (flags_flit || in.last)) state_nx = DRAIN;
      DRAIN:   if (out_ready[sel] && rd_last) state_nx = pkt_done ? COLLECT : STREAM;
      STREAM:  if (in.valid && out_ready[sel] && in.last) state_nx = COLLECT;
      default: state_nx = COLLECT;
    endcase
  end

  // Output logic: one shared flit fanned out, valid only on the selected link.
  always_comb begin
    cur      = in;
    in_ready = 1'b0;
    case (state)
      COLLECT: begin
        in_ready  = 1'b1;
        cur.valid = 1'b0;
      end
      DRAIN: begin
        cur.data  = hdr_data[rd];
        cur.last  = hdr_last[rd];
        cur.valid = 1'b1;
      end
      STREAM: begin
        // cut-through: ready path from the selected output back to the input
        in_ready = out_ready[sel];
      end
      default: cur.valid = 1'b0;
    endcase
    for (int i = 0; i < N_OUT; i++) begin
      out[i]       = cur;
      out[i].valid = cur.valid && (sel == SW'(i));
    end
  end

endmodule
